// File: rtl/msm_window_feeder.sv
// Window-digit feeder for the MSM bucket stage: extracts one scalar window digit per
// input pair and packs two (digit, point) pairs into each output beat.
module msm_window_feeder #(
    parameter int SCALAR_WIDTH = 32,
    parameter int POINT_WIDTH  = 96,
    parameter int INDEX_WIDTH  = 4,
    parameter int WSEL_WIDTH   = 3,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [COUNT_WIDTH-1:0]  num_pairs,
    input  logic [WSEL_WIDTH-1:0]   window_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SCALAR_WIDTH-1:0] in_scalar,
    input  logic [POINT_WIDTH-1:0]  in_point,
    input  logic                    stall,
    output logic                    out_valid,
    output logic [INDEX_WIDTH-1:0]  scalar_label_1,
    output logic [INDEX_WIDTH-1:0]  scalar_label_2,
    output logic [POINT_WIDTH-1:0]  points_label_1,
    output logic [POINT_WIDTH-1:0]  points_label_2,
    output logic                    lane_valid_1,
    output logic                    lane_valid_2,
    output logic                    write_over,
    output logic                    done,
    output logic                    busy,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_DRAIN = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [COUNT_WIDTH-1:0]  r_remaining;
    logic [WSEL_WIDTH-1:0]   r_wsel;
    logic                    r_hold_full;
    logic [INDEX_WIDTH-1:0]  r_hold_digit;
    logic [POINT_WIDTH-1:0]  r_hold_point;

    logic                    r_out_valid;
    logic [INDEX_WIDTH-1:0]  r_lab1;
    logic [INDEX_WIDTH-1:0]  r_lab2;
    logic [POINT_WIDTH-1:0]  r_pt1;
    logic [POINT_WIDTH-1:0]  r_pt2;
    logic                    r_lv1;
    logic                    r_lv2;

    logic [SCALAR_WIDTH-1:0] w_scalar_sh;
    logic [INDEX_WIDTH-1:0]  w_digit;
    logic                    w_slot_free;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_pair_beat;
    logic                    w_pair_load;
    logic                    w_flush_load;
    logic                    w_load;
    logic                    w_l1_valid;
    logic                    w_l2_valid;

    assign w_scalar_sh = in_scalar >> (r_wsel * INDEX_WIDTH);
    assign w_digit     = w_scalar_sh[INDEX_WIDTH-1:0];
    assign w_slot_free = !r_out_valid || !stall;

    // The hold slot can always take a pair; completing a pair needs room in the output register.
    assign w_in_ready  = (r_state == S_RUN) && (r_remaining != '0) && (!r_hold_full || w_slot_free);
    assign w_accept    = in_valid && w_in_ready;

    assign w_pair_beat  = w_accept && r_hold_full;
    assign w_pair_load  = w_pair_beat && ((r_hold_digit != '0) || (w_digit != '0));
    assign w_flush_load = (r_state == S_FLUSH) && w_slot_free && (r_hold_digit != '0);
    assign w_load       = w_pair_load || w_flush_load;
    assign w_l1_valid   = (r_hold_digit != '0);
    assign w_l2_valid   = w_pair_beat && (w_digit != '0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (num_pairs == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (r_remaining == '0) begin
                    w_next_state = r_hold_full ? S_FLUSH : S_DRAIN;
                end
            end
            S_FLUSH: begin
                if (w_slot_free) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_out_valid) begin
                    w_next_state = S_FIN;
                end
            end
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining  <= '0;
            r_wsel       <= '0;
            r_hold_full  <= 1'b0;
            r_hold_digit <= '0;
            r_hold_point <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_remaining <= num_pairs;
                r_wsel      <= window_sel;
                r_hold_full <= 1'b0;
            end
            if (w_accept) begin
                r_remaining <= r_remaining - 1'b1;
                if (r_hold_full) begin
                    r_hold_full <= 1'b0;
                end else begin
                    r_hold_full  <= 1'b1;
                    r_hold_digit <= w_digit;
                    r_hold_point <= in_point;
                end
            end
            if ((r_state == S_FLUSH) && w_slot_free) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // Loading only happens when the slot is free, so a stalled beat is never overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_lab1      <= '0;
            r_lab2      <= '0;
            r_pt1       <= '0;
            r_pt2       <= '0;
            r_lv1       <= 1'b0;
            r_lv2       <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_lv1       <= w_l1_valid;
            r_lv2       <= w_l2_valid;
            r_lab1      <= w_l1_valid ? r_hold_digit : '0;
            r_pt1       <= w_l1_valid ? r_hold_point : '0;
            r_lab2      <= w_l2_valid ? w_digit : '0;
            r_pt2       <= w_l2_valid ? in_point : '0;
        end else if (r_out_valid && !stall) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready       = w_in_ready;
    assign out_valid      = r_out_valid;
    assign scalar_label_1 = r_lab1;
    assign scalar_label_2 = r_lab2;
    assign points_label_1 = r_pt1;
    assign points_label_2 = r_pt2;
    assign lane_valid_1   = r_lv1;
    assign lane_valid_2   = r_lv2;
    assign write_over     = (r_state == S_FIN);
    assign done           = (r_state == S_FIN);
    assign busy           = (r_state != S_IDLE);
    assign dbg_state      = r_state;

endmodule
